// File: rtl/status_uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | status_uart_pkg : shared state encodings and defaults for status_uart_tx.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package status_uart_pkg;

   localparam int c_default_depth = 8;
   localparam int c_default_div_w = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/status_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | status_fifo : synchronous byte FIFO, first-word fall-through read port.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module status_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [7:0]              i_din,
   input  logic                    i_pop,
   output logic [7:0]              o_dout,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_level
);

   localparam int c_aw = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [c_aw:0] r_wr_ptr;
   logic [c_aw:0] r_rd_ptr;
   logic          w_push_ok;
   logic          w_pop_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_dout    = r_mem[r_rd_ptr[c_aw-1:0]];
   assign o_level   = r_wr_ptr - r_rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= i_din;
   end

endmodule
`default_nettype wire

// File: rtl/status_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | status_uart_tx : FIFO-buffered 8N1 UART transmitter, LSB first.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module status_uart_tx
   import status_uart_pkg::*;
#(
   parameter int DEPTH = c_default_depth,
   parameter int DIV_W = c_default_div_w
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [DIV_W-1:0]        clk_div,
   input  logic [7:0]              tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic                    tx_o,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level
);

   uart_state_t      r_state;
   uart_state_t      w_state_nxt;
   logic [7:0]       r_shift;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_baud;
   logic [2:0]       r_bit_cnt;
   logic             r_tx;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_tick;
   logic [7:0]       w_fifo_dout;

   status_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .i_push  (tx_valid),
      .i_din   (tx_data),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (level)
   );

   assign tx_ready = !w_full;
   assign busy     = (r_state != ST_IDLE) || !w_empty;
   assign tx_o     = r_tx;
   assign w_tick   = (r_baud == r_div);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: if (w_tick) w_state_nxt = ST_DATA;
         ST_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
         ST_STOP: begin
            // Chain straight into the next start bit so frames stay contiguous.
            if (w_tick) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_shift   <= '0;
         r_div     <= '0;
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
      end else if (w_pop) begin
         // Divisor is captured per frame; later changes apply to the next frame.
         r_shift   <= w_fifo_dout;
         r_div     <= clk_div;
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b0;
      end else if (r_state != ST_IDLE) begin
         if (!w_tick) begin
            r_baud <= r_baud + 1'b1;
         end else begin
            r_baud <= '0;
            case (r_state)
               ST_START: r_tx <= r_shift[0];
               ST_DATA: begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_shift   <= r_shift >> 1;
                  r_tx      <= (r_bit_cnt == 3'd7) ? 1'b1 : r_shift[1];
               end
               default: r_tx <= 1'b1;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
